mem_burst_reader: RTL and testbench
===================================

# mem_burst_reader

Sequential read initiator for the 8-bit, 256-byte data memory. On a start command it walks a contiguous address range through the memory's combinational read port and streams the bytes out on a valid/ready interface, flagging the last byte and pulsing `done` at the end. It sits between the data memory and any byte consumer, such as a checksum unit or output port, and never asserts the memory write enable.

## Interface
- `AW`, 8: memory address width; pointer wraps modulo 2^AW.
- `DW`, 8: data width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request pulse; sampled only in IDLE.
- `base_addr`  in  AW  first address of the burst; latched on accepted start.
- `len`  in  AW+1  byte count, 0..256; values above 256 are clamped to 256; latched on accepted start.
- `mem_addr`  out  AW  address driven to the memory read port.
- `mem_wr_en`  out  1  tied 0.
- `mem_rd_data`  in  DW  combinational read data for `mem_addr`.
- `out_data`  out  DW  stream byte, registered.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the byte when `out_valid` and `out_ready` are both high at a rising edge.
- `out_last`  out  1  qualifies the final byte of the burst.
- `busy`  out  1  high in READ and DRAIN.
- `done`  out  1  one-cycle pulse at burst completion.

## Operation
- States: IDLE, READ, DRAIN.
- **IDLE**
  - `start`=1 with clamped `len` > 0: latch `ptr`=`base_addr` and `remaining`=`len`, then go to READ.
  - `start`=1 with `len`=0: no beats; `done` pulses in the next cycle; stay in IDLE.
- **READ**
  - `mem_addr`=`ptr` combinationally from the register.
  - Load condition: `!out_valid || out_ready`.
  - When the load condition holds, on the edge:
    - `out_data` ← `mem_rd_data`
    - `out_valid` ← 1
    - `out_last` ← (`remaining`==1)
    - `ptr` ← `ptr`+1, wrapping from 255 to 0
    - `remaining` ← `remaining`−1
  - When the byte with `remaining`==1 is loaded, go to DRAIN.
  - When the load condition is false, `out_data`, `out_valid` and `out_last` are held unchanged, and so are `ptr` and `remaining`.
- **DRAIN**
  - Hold the output register until the last beat is accepted (`out_valid && out_ready`).
  - On that edge: `out_valid`←0, `out_last`←0, `done`←1 for one cycle, go to IDLE.
- **Beat accepted in READ without a reload:** unreachable, because acceptance implies the load condition.
- **Start while busy:** ignored. The latched `base_addr`/`len` are unaffected by input changes during the burst.
- **Memory contents:** sampled at the cycle the byte is loaded. Writes by other agents to not-yet-read addresses are visible; writes to already-read addresses are not.
- **`mem_addr` in IDLE and DRAIN:** holds the last `ptr` value.
- **Reset:** asynchronous assertion, at any point, returns the block to IDLE with all outputs at their reset values. It also clears `ptr` and `remaining`. Any in-flight beat is dropped with no `done`.

## Timing
- Reset values:
  - `out_valid`=0, `out_last`=0, `out_data`=0
  - `busy`=0, `done`=0
  - `mem_addr`=0, `mem_wr_en`=0
- **Start to first byte:** `start` is sampled at edge E0; first `out_valid`=1 after edge E1.
- **Throughput:** with `out_ready` held high, one byte per cycle. N bytes occupy cycles E1..E(N).
- **`done` position:** pulses in the cycle after the edge that accepts the last beat. With `out_ready` held high, that is after edge E(N+1).
- **`busy`:** high from E0+ until the edge that raises `done`; `busy` and `done` are never both high.
- **`len`=0:** `done` is high after E1; `busy` never rises.
- **Back-to-back bursts:** a new `start` can be accepted in the same cycle `done` is high, because the block is in IDLE.
- **Back-pressure:** the block never drops or duplicates a byte.

## Test plan
- **Basic burst:** memory[i]=i for all i; `base_addr`=0x10, `len`=4, `out_ready`=1.
  - Bytes 0x10, 0x11, 0x12, 0x13 on four consecutive cycles starting E1.
  - `out_last` only on 0x13; `done` one cycle after E5; `mem_wr_en` stays 0.
- **Wrap-around:** `base_addr`=0xFE, `len`=4 → bytes from addresses 0xFE, 0xFF, 0x00, 0x01 in that order.
- **Full memory:** `len`=256 → 256 beats with `ptr` wrapping back to the base; `len`=300 behaves identically.
- **Back-pressure:** `len`=3 with `out_ready` toggling 1,0,0,1,0,1.
  - Each byte held stable while `out_ready`=0; exactly 3 acceptances, in order; single `done`.
- **Edge commands:**
  - `len`=0 → `done` after E1, no `out_valid`, `busy` stays 0.
  - `start` asserted while busy with a different `base_addr` → no effect on the current burst.
- **Reset mid-burst:** assert `rst_n`=0 during the second beat of an 8-byte burst.
  - All outputs take their reset values immediately, with no `done`.
  - A fresh start after release produces a correct burst.

Source files
------------

// File: rtl/mem_burst_reader.sv
// Sequential burst reader: walks a contiguous, wrapping address range through a
// combinational memory read port and streams the bytes out over valid/ready.
`timescale 1ns/1ps
module mem_burst_reader #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_rd_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0]   LEN_MAX  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LEN_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   REM_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_r;
  state_t        next_state_s;
  logic [AW-1:0] ptr_r;
  logic [AW:0]   remaining_r;
  logic [AW:0]   len_clamped_s;
  logic          load_s;
  logic          accept_s;
  logic [DW-1:0] out_data_r;
  logic          out_valid_r;
  logic          out_last_r;
  logic          done_r;
  logic          zero_pend_r;

  // Length clamp, handshake qualifiers and next-state selection.
  always_comb begin
    len_clamped_s = (len > LEN_MAX) ? LEN_MAX : len;
    load_s        = !out_valid_r || out_ready;
    accept_s      = out_valid_r && out_ready;
    next_state_s  = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && (len_clamped_s != LEN_ZERO)) next_state_s = ST_READ;
        else                                      next_state_s = ST_IDLE;
      end
      ST_READ: begin
        if (load_s && (remaining_r == REM_ONE)) next_state_s = ST_DRAIN;
        else                                    next_state_s = ST_READ;
      end
      ST_DRAIN: begin
        if (accept_s) next_state_s = ST_IDLE;
        else          next_state_s = ST_DRAIN;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Pointer, byte counter and registered stream outputs. A zero-length
  // request is delayed one cycle so done lands where an N=0 burst would put it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= {AW{1'b0}};
      remaining_r <= LEN_ZERO;
      out_data_r  <= {DW{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
      zero_pend_r <= 1'b0;
    end else begin
      done_r      <= zero_pend_r;
      zero_pend_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (len_clamped_s == LEN_ZERO) begin
              zero_pend_r <= 1'b1;
            end else begin
              ptr_r       <= base_addr;
              remaining_r <= len_clamped_s;
            end
          end
        end
        ST_READ: begin
          if (load_s) begin
            out_data_r  <= mem_rd_data;
            out_valid_r <= 1'b1;
            out_last_r  <= (remaining_r == REM_ONE);
            ptr_r       <= ptr_r + PTR_ONE;
            remaining_r <= remaining_r - REM_ONE;
          end
        end
        ST_DRAIN: begin
          if (accept_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            done_r      <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = ptr_r;
  assign mem_wr_en = 1'b0;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = (state_r != ST_IDLE);
  assign done      = done_r;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed self-checking bench for mem_burst_reader with a behavioural 256-byte
// memory; each task drives one scenario and checks against hand-computed values.
`timescale 1ns/1ps
module tb_mem_burst_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] len;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  assign mem_rd_data = mem[mem_addr];

  int errors = 0;
  int checks = 0;

  logic [7:0] q_data[$];
  logic       q_last[$];
  int         q_idx[$];
  int         q_done[$];
  int first_valid, overlap, unstable, wr_seen, busy_cnt, timed_out;

  mem_burst_reader #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a start, then observe 1ns after every edge (index e = after edge E(e)).
  // out_ready for the cycle after E(e), e>=1, is rpat[e-1] for e-1 < rn, else 1.
  task automatic run_burst(input logic [7:0] base, input logic [8:0] l,
                           input logic [15:0] rpat, input int rn, input int ndone,
                           input int rs_at, input logic [7:0] rs_base,
                           input logic [8:0] rs_len, input int maxcyc);
    int e;
    int extra;
    bit pend;
    logic [7:0] pd;
    logic pl;
    q_data.delete(); q_last.delete(); q_idx.delete(); q_done.delete();
    first_valid = -1; overlap = 0; unstable = 0; wr_seen = 0; busy_cnt = 0; timed_out = 0;
    start = 1'b1; base_addr = base; len = l; out_ready = 1'b1;
    @(posedge clk); #1;
    e = 0; extra = 0; pend = 1'b0; pd = 8'h00; pl = 1'b0;
    while (extra < 3) begin
      if (e >= maxcyc) begin
        timed_out = 1;
        break;
      end
      start = 1'b0; base_addr = ~base; len = 9'd5;
      if (e == rs_at) begin
        start = 1'b1; base_addr = rs_base; len = rs_len;
      end
      out_ready = (e >= 1 && (e - 1) < rn) ? rpat[e-1] : 1'b1;
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (mem_wr_en) wr_seen++;
      if (done) q_done.push_back(e);
      if (out_valid && first_valid < 0) first_valid = e;
      if (pend && (!out_valid || out_data !== pd || out_last !== pl)) unstable++;
      pend = out_valid && !out_ready; pd = out_data; pl = out_last;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data); q_last.push_back(out_last); q_idx.push_back(e);
      end
      if (q_done.size() >= ndone) extra++;
      @(posedge clk); #1;
      e++;
    end
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; base_addr = 8'h00; len = 9'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, out_data, busy, done, mem_addr, mem_wr_en} !== 21'd0) begin
      errors++;
      $display("FAIL reset_values: got %h want 0",
               {out_valid, out_last, out_data, busy, done, mem_addr, mem_wr_en});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run_burst(8'h10, 9'd4, 16'h0000, 0, 1, -1, 8'h00, 9'd0, 40);
    checks++;
    if (timed_out != 0 || q_data.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d beats timeout=%0d want 4", q_data.size(), timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_data.size() || q_data[i] !== 8'(8'h10 + i) || q_last[i] !== (i == 3) || q_idx[i] != i + 1) begin
        errors++; $display("FAIL basic_beat%0d: got data/last/cycle %h/%b/%0d want %h/%b/%0d",
                           i, (i < q_data.size()) ? q_data[i] : 8'hxx, (i < q_last.size()) ? q_last[i] : 1'bx,
                           (i < q_idx.size()) ? q_idx[i] : -1, 8'(8'h10 + i), (i == 3), i + 1);
      end
    end
    checks++;
    if (first_valid != 1) begin errors++; $display("FAIL basic_first_valid: got %0d want 1", first_valid); end
    checks++;
    if (q_done.size() != 1 || q_done[0] != 5) begin
      errors++; $display("FAIL basic_done: got %0d pulses first at %0d want 1 at 5",
                         q_done.size(), (q_done.size() > 0) ? q_done[0] : -1);
    end
    checks++;
    if (busy_cnt != 5 || overlap != 0) begin
      errors++; $display("FAIL basic_busy: got %0d busy cycles overlap=%0d want 5 overlap=0", busy_cnt, overlap);
    end
    checks++;
    if (wr_seen != 0) begin errors++; $display("FAIL basic_wr_en: got %0d cycles high want 0", wr_seen); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_w [4];
    exp_w = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_burst(8'hFE, 9'd4, 16'h0000, 0, 1, -1, 8'h00, 9'd0, 40);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_data.size() || q_data[i] !== exp_w[i]) begin
        errors++; $display("FAIL wrap_beat%0d: got %h want %h", i,
                           (i < q_data.size()) ? q_data[i] : 8'hxx, exp_w[i]);
      end
    end
    checks++;
    if (mem_addr !== 8'h02) begin errors++; $display("FAIL wrap_ptr: got %h want 02", mem_addr); end
  endtask

  task automatic test_full;
    logic [7:0] b;
    logic [8:0] l;
    int bad;
    for (int r = 0; r < 2; r++) begin
      b = (r == 0) ? 8'h80 : 8'h03;
      l = (r == 0) ? 9'd256 : 9'd300;
      run_burst(b, l, 16'h0000, 0, 1, -1, 8'h00, 9'd0, 400);
      checks++;
      if (timed_out != 0 || q_data.size() != 256) begin
        errors++; $display("FAIL full%0d_count: got %0d beats timeout=%0d want 256", r, q_data.size(), timed_out);
      end
      bad = 0;
      for (int i = 0; i < q_data.size(); i++)
        if (q_data[i] !== 8'(b + i) || q_last[i] !== (i == 255)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL full%0d_data: got %0d bad beats want 0", r, bad); end
      checks++;
      if (q_done.size() != 1 || q_done[0] != 257) begin
        errors++; $display("FAIL full%0d_done: got %0d pulses first at %0d want 1 at 257",
                           r, q_done.size(), (q_done.size() > 0) ? q_done[0] : -1);
      end
      checks++;
      if (mem_addr !== b) begin errors++; $display("FAIL full%0d_ptr: got %h want %h", r, mem_addr, b); end
    end
  endtask

  task automatic test_backpressure;
    int exp_idx [3];
    exp_idx = '{1, 4, 6};
    run_burst(8'h40, 9'd3, 16'b0000_0000_0010_1001, 6, 1, -1, 8'h00, 9'd0, 40);
    checks++;
    if (q_data.size() != 3 || unstable != 0) begin
      errors++; $display("FAIL bp_count: got %0d beats unstable=%0d want 3 unstable=0", q_data.size(), unstable);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= q_data.size() || q_data[i] !== 8'(8'h40 + i) || q_last[i] !== (i == 2) || q_idx[i] != exp_idx[i]) begin
        errors++; $display("FAIL bp_beat%0d: got data/cycle %h/%0d want %h/%0d", i,
                           (i < q_data.size()) ? q_data[i] : 8'hxx, (i < q_idx.size()) ? q_idx[i] : -1,
                           8'(8'h40 + i), exp_idx[i]);
      end
    end
    checks++;
    if (q_done.size() != 1 || q_done[0] != 7) begin
      errors++; $display("FAIL bp_done: got %0d pulses first at %0d want 1 at 7",
                         q_done.size(), (q_done.size() > 0) ? q_done[0] : -1);
    end
  endtask

  task automatic test_len_zero;
    run_burst(8'h22, 9'd0, 16'h0000, 0, 1, -1, 8'h00, 9'd0, 20);
    checks++;
    if (first_valid != -1 || q_data.size() != 0 || busy_cnt != 0) begin
      errors++; $display("FAIL len0_quiet: got first_valid=%0d beats=%0d busy=%0d want -1/0/0",
                         first_valid, q_data.size(), busy_cnt);
    end
    checks++;
    if (q_done.size() != 1 || q_done[0] != 1) begin
      errors++; $display("FAIL len0_done: got %0d pulses first at %0d want 1 at 1",
                         q_done.size(), (q_done.size() > 0) ? q_done[0] : -1);
    end
  endtask

  task automatic test_start_busy;
    run_burst(8'h70, 9'd4, 16'h0000, 0, 1, 2, 8'h00, 9'd2, 40);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_data.size() || q_data[i] !== 8'(8'h70 + i)) begin
        errors++; $display("FAIL busy_start_beat%0d: got %h want %h", i,
                           (i < q_data.size()) ? q_data[i] : 8'hxx, 8'(8'h70 + i));
      end
    end
    checks++;
    if (q_data.size() != 4 || q_done.size() != 1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL busy_start_extra: got beats=%0d dones=%0d busy=%b valid=%b want 4/1/0/0",
                         q_data.size(), q_done.size(), busy, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d [6];
    int exp_i [6];
    exp_d = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61};
    exp_i = '{1, 2, 3, 4, 7, 8};
    run_burst(8'h50, 9'd4, 16'h0000, 0, 2, 5, 8'h60, 9'd2, 40);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= q_data.size() || q_data[i] !== exp_d[i] || q_idx[i] != exp_i[i] || q_last[i] !== (i == 3 || i == 5)) begin
        errors++; $display("FAIL b2b_beat%0d: got data/cycle %h/%0d want %h/%0d", i,
                           (i < q_data.size()) ? q_data[i] : 8'hxx, (i < q_idx.size()) ? q_idx[i] : -1,
                           exp_d[i], exp_i[i]);
      end
    end
    checks++;
    if (q_done.size() != 2 || q_done[0] != 5 || q_done[1] != 9 || overlap != 0) begin
      errors++; $display("FAIL b2b_done: got %0d pulses at %0d,%0d overlap=%0d want 2 at 5,9 overlap=0",
                         q_done.size(), (q_done.size() > 0) ? q_done[0] : -1,
                         (q_done.size() > 1) ? q_done[1] : -1, overlap);
    end
  endtask

  task automatic test_reset_mid;
    int done_seen;
    start = 1'b1; base_addr = 8'h20; len = 9'd8; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h21) begin
      errors++; $display("FAIL rstmid_pre: got valid=%b data=%h want 1/21", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, out_data, busy, done, mem_addr, mem_wr_en} !== 21'd0) begin
      errors++; $display("FAIL rstmid_async: got %h want 0",
                         {out_valid, out_last, out_data, busy, done, mem_addr, mem_wr_en});
    end
    done_seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done || busy || out_valid) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL rstmid_hold: got %0d active cycles want 0", done_seen); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst(8'h30, 9'd3, 16'h0000, 0, 1, -1, 8'h00, 9'd0, 40);
    checks++;
    if (q_data.size() != 3 || q_data[0] !== 8'h30 || q_data[1] !== 8'h31 || q_data[2] !== 8'h32 ||
        q_done.size() != 1 || q_done[0] != 4) begin
      errors++; $display("FAIL rstmid_restart: got beats=%0d dones=%0d want 3 beats 30..32 done at 4",
                         q_data.size(), q_done.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_backpressure();
    test_len_zero();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
